// File: rtl/fm_special_pipe_pkg.sv
// fm_special_pipe_pkg: shared types, default widths and special-value constants for the fp multiplier
package fm_special_pipe_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_SIG_W = 23;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
        logic snan;
    } fm_class_t;

    // {exp,sig} of +infinity, right-aligned in 64 bits
    function automatic logic [63:0] const_infinity(input int exp_w, input int sig_w);
        return ((64'd1 << exp_w) - 64'd1) << sig_w;
    endfunction

    // {exp,sig} of the canonical quiet NaN produced for inf*0
    function automatic logic [63:0] const_nan(input int exp_w, input int sig_w);
        return const_infinity(exp_w, sig_w) | (64'd1 << (sig_w - 1));
    endfunction

    function automatic logic [63:0] const_zero(input int exp_w, input int sig_w);
        return 64'd0 & 64'(exp_w + sig_w);
    endfunction

endpackage

// File: rtl/fm_classify.sv
// fm_classify: combinational zero/inf/NaN/sNaN classification of one {exp,sig} operand
module fm_classify
    import fm_special_pipe_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int SIG_W = DEF_SIG_W
) (
    input  logic [EXP_W+SIG_W-1:0] i_op,
    output fm_class_t              o_cls
);

    logic w_ones;
    logic w_sig_nz;

    assign w_ones   = &i_op[EXP_W+SIG_W-1:SIG_W];
    assign w_sig_nz = |i_op[SIG_W-1:0];

    // denormals count as zero because the multiplier flushes them
    always_comb begin
        o_cls.zero = ~|i_op[EXP_W+SIG_W-1:SIG_W];
        o_cls.inf  = w_ones & ~w_sig_nz;
        o_cls.nan  = w_ones & w_sig_nz;
        o_cls.snan = w_ones & w_sig_nz & ~i_op[SIG_W-1];
    end

endmodule

// File: rtl/fm_special_pipe.sv
// fm_special_pipe: two-stage valid/ready special-case unit (zero/inf/NaN) beside the multiplier datapath
module fm_special_pipe
    import fm_special_pipe_pkg::*;
#(
    parameter int EXP_W     = DEF_EXP_W,
    parameter int SIG_W     = DEF_SIG_W,
    parameter int NAN_MODE  = 0,
    parameter int QUIET_NAN = 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [EXP_W+SIG_W:0]     i_a,
    input  logic [EXP_W+SIG_W:0]     i_b,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [EXP_W+SIG_W-1:0]   o_special,
    output logic                     o_specialsign,
    output logic                     o_specialcase,
    output logic                     o_specialsigncase,
    output logic                     o_invalid,
    output logic                     o_flag_invalid,
    input  logic                     i_clr_flags
);

    localparam int WIDTH = 1 + EXP_W + SIG_W;
    localparam logic [WIDTH-2:0] CONSTNAN      = (WIDTH-1)'(const_nan(EXP_W, SIG_W));
    localparam logic [WIDTH-2:0] CONSTINFINITY = (WIDTH-1)'(const_infinity(EXP_W, SIG_W));
    localparam logic [WIDTH-2:0] CONSTZERO     = (WIDTH-1)'(const_zero(EXP_W, SIG_W));
    localparam logic [WIDTH-2:0] QUIET_BIT     = (QUIET_NAN != 0) ? (WIDTH-1)'(64'd1 << (SIG_W - 1)) : '0;

    fm_class_t w_ca, w_cb;
    logic      w_adv1, w_adv2;

    logic             r_s1_valid;
    fm_class_t        r_ca, r_cb;
    logic [WIDTH-1:0] r_a, r_b;

    logic             r_s2_valid;
    logic [WIDTH-2:0] r_special;
    logic             r_sign, r_case, r_sigcase, r_invalid;
    logic             r_flag;

    logic             w_a_first, w_any_nan, w_inf_zero;
    logic [WIDTH-1:0] w_pick;
    logic [WIDTH-2:0] w_special;
    logic             w_sign, w_case, w_sigcase, w_invalid;

    fm_classify #(.EXP_W(EXP_W), .SIG_W(SIG_W)) u_cls_a (.i_op(i_a[WIDTH-2:0]), .o_cls(w_ca));
    fm_classify #(.EXP_W(EXP_W), .SIG_W(SIG_W)) u_cls_b (.i_op(i_b[WIDTH-2:0]), .o_cls(w_cb));

    assign w_adv2     = ~r_s2_valid | i_out_ready;
    assign w_adv1     = ~r_s1_valid | w_adv2;
    assign o_in_ready = w_adv1;

    // special-result selection from the stage-1 operands, NaN > inf*0 > zero > inf
    always_comb begin
        w_a_first  = (NAN_MODE == 0) ? r_ca.nan & (~r_cb.nan | (r_a[SIG_W-1:0] >= r_b[SIG_W-1:0])) : r_ca.nan;
        w_pick     = w_a_first ? r_a : r_b;
        w_any_nan  = r_ca.nan | r_cb.nan;
        w_inf_zero = (r_ca.inf & r_cb.zero) | (r_ca.zero & r_cb.inf);
        w_special  = w_any_nan ? (w_pick[WIDTH-2:0] | QUIET_BIT) :
                     w_inf_zero ? CONSTNAN :
                     (r_ca.zero | r_cb.zero) ? CONSTZERO :
                     (r_ca.inf | r_cb.inf) ? CONSTINFINITY : CONSTZERO;
        w_sign     = w_any_nan ? w_pick[WIDTH-1] : w_inf_zero ? 1'b1 : r_a[WIDTH-1] ^ r_b[WIDTH-1];
        w_case     = w_any_nan | r_ca.zero | r_cb.zero | r_ca.inf | r_cb.inf;
        w_sigcase  = w_inf_zero | w_any_nan;
        w_invalid  = w_inf_zero | r_ca.snan | r_cb.snan;
    end

    // stage 1: capture operands and their classification
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_valid <= 1'b0;
            r_ca       <= '0;
            r_cb       <= '0;
            r_a        <= '0;
            r_b        <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= i_in_valid;
            if (i_in_valid) begin
                r_ca <= w_ca;
                r_cb <= w_cb;
                r_a  <= i_a;
                r_b  <= i_b;
            end
        end
    end

    // stage 2: capture the selected result, held while the consumer stalls
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s2_valid <= 1'b0;
            r_special  <= '0;
            r_sign     <= 1'b0;
            r_case     <= 1'b0;
            r_sigcase  <= 1'b0;
            r_invalid  <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_special <= w_special;
                r_sign    <= w_sign;
                r_case    <= w_case;
                r_sigcase <= w_sigcase;
                r_invalid <= w_invalid;
            end
        end
    end

    // sticky invalid: only transferred results set it, and a set beats a same-cycle clear
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_flag <= 1'b0;
        else if (r_s2_valid & i_out_ready & r_invalid)
            r_flag <= 1'b1;
        else if (i_clr_flags)
            r_flag <= 1'b0;
    end

    assign o_out_valid       = r_s2_valid;
    assign o_special         = r_special;
    assign o_specialsign     = r_sign;
    assign o_specialcase     = r_case;
    assign o_specialsigncase = r_sigcase;
    assign o_invalid         = r_invalid;
    assign o_flag_invalid    = r_flag;

endmodule

// File: tb/tb_fm_special_pipe.sv
// tb_fm_special_pipe: directed checks of the special-case pipe in both NaN modes
module tb_fm_special_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        clr_flags = 1'b0;
    logic [31:0] ia = '0, ib = '0;

    logic        in_ready, out_valid, sign, scase, ssigncase, invalid, flag;
    logic [30:0] special;
    logic        m1_in_ready, m1_out_valid, m1_sign, m1_scase, m1_ssigncase, m1_invalid, m1_flag;
    logic [30:0] m1_special;

    int n_chk = 0;
    int n_fail = 0;
    int idx, nrx;
    logic [30:0] rx [5];

    fm_special_pipe dut (
        .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_a(ia), .i_b(ib), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_special(special), .o_specialsign(sign), .o_specialcase(scase),
        .o_specialsigncase(ssigncase), .o_invalid(invalid), .o_flag_invalid(flag),
        .i_clr_flags(clr_flags)
    );

    fm_special_pipe #(.NAN_MODE(1), .QUIET_NAN(0)) dut_m1 (
        .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .o_in_ready(m1_in_ready),
        .i_a(ia), .i_b(ib), .o_out_valid(m1_out_valid), .i_out_ready(out_ready),
        .o_special(m1_special), .o_specialsign(m1_sign), .o_specialcase(m1_scase),
        .o_specialsigncase(m1_ssigncase), .o_invalid(m1_invalid), .o_flag_invalid(m1_flag),
        .i_clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one operand pair into an empty pipe; returns at the negedge where the result is presented
    task automatic run(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        ia = a;
        ib = b;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_flag", flag, 0);
        check("rst_special", special, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        run(32'h7FC00001, 32'h7FC00002);
        check("nan_valid", out_valid, 1);
        check("nan_m0", special, 64'h7FC00002);
        check("nan_m1", m1_special, 64'h7FC00001);
        check("nan_sign", sign, 0);
        check("nan_case", scase, 1);
        check("nan_sigcase", ssigncase, 1);
        check("nan_invalid", invalid, 0);

        run(32'h7F800000, 32'h00000000);
        check("infzero", special, 64'h7FC00000);
        check("infzero_sign", sign, 1);
        check("infzero_invalid", invalid, 1);
        check("infzero_flag_before", flag, 0);
        @(negedge clk);
        check("infzero_flag", flag, 1);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("flag_cleared", flag, 0);

        run(32'h00000000, 32'hFF800000);
        check("zeroinf", special, 64'h7FC00000);
        check("zeroinf_sign", sign, 1);
        check("zeroinf_invalid", invalid, 1);

        run(32'h00000001, 32'h7F800000);
        check("denorm_inf", special, 64'h7FC00000);
        check("denorm_inf_inv", invalid, 1);

        run(32'h7F800001, 32'h3F800000);
        check("snan_quiet", special, 64'h7FC00001);
        check("snan_raw", m1_special, 64'h7F800001);
        check("snan_invalid", invalid, 1);
        check("snan_sign", sign, 0);

        run(32'hFFC00005, 32'h7FC00005);
        check("nan_tie_a_sign", sign, 1);
        check("nan_tie_a", special, 64'h7FC00005);

        run(32'h3F800000, 32'h40000000);
        check("normal_case", scase, 0);
        check("normal_special", special, 0);
        check("normal_sigcase", ssigncase, 0);

        run(32'h80000000, 32'h3F800000);
        check("zero_special", special, 0);
        check("zero_sign", sign, 1);
        check("zero_case", scase, 1);
        check("zero_invalid", invalid, 0);

        run(32'hFF800000, 32'h40000000);
        check("inf_special", special, 64'h7F800000);
        check("inf_sign", sign, 1);
        check("inf_sigcase", ssigncase, 0);

        // stall: five back-to-back inputs, consumer blocked for the first four cycles
        idx = 0;
        nrx = 0;
        for (int cyc = 0; cyc < 40 && nrx < 5; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 4);
            in_valid  = (idx < 5);
            ia = 32'h7FC00001 + 32'(idx);
            ib = 32'h3F800000;
            #1;
            if (cyc == 2 || cyc == 3) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_hold", special, 64'h7FC00001);
            end
            if (out_valid && out_ready) begin
                rx[nrx] = special;
                nrx++;
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        check("stall_count", 64'(nrx), 5);
        for (int k = 0; k < 5; k++) check("stall_order", rx[k], 64'h7FC00001 + 64'(k));
        @(negedge clk);
        check("stall_no_dup", out_valid, 0);

        // invalid transfer with a same-cycle clear: set wins, then the clear alone takes effect
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        run(32'h7F800000, 32'h00000000);
        clr_flags = 1'b1;
        @(negedge clk);
        check("set_beats_clr", flag, 1);
        @(negedge clk);
        clr_flags = 1'b0;
        check("clr_alone", flag, 0);

        // reset with two results in flight
        run(32'h7F800000, 32'h00000000);
        @(negedge clk);
        check("pre_reset_flag", flag, 1);
        out_ready = 1'b0;
        in_valid = 1'b1;
        ia = 32'h7F800001;
        ib = 32'h3F800000;
        @(negedge clk);
        ia = 32'h7FC00003;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_reset_valid", out_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_flag", flag, 0);
        check("reset_special", special, 0);
        check("reset_in_ready", in_ready, 1);
        reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_stale", out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
